// File: rtl/pdp_bram_pipe.sv
// Pseudo-dual-port block RAM with byte-enable writes, a lockable
// read pipeline, per-beat valid tracking and an optional write bypass.
module pdp_bram_pipe #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int MEM_DEPTH  = 'h4000,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int WR_BYPASS  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wren,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wrbe,
  input  logic [ADDR_WIDTH-1:0]            wraddr,
  input  logic [DATA_WIDTH-1:0]            wrdata,
  input  logic                             lock,
  input  logic                             rden,
  input  logic [ADDR_WIDTH-1:0]            rdaddr,
  output logic [DATA_WIDTH-1:0]            rddata,
  output logic                             rdvalid
);

  localparam int NBE = DATA_WIDTH / BYTE_WIDTH;
  localparam int MW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH =
    (ADDR_WIDTH+1)'(MEM_DEPTH);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
    $error("pdp_bram_pipe: RD_LATENCY must be 1..4");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
    $error("pdp_bram_pipe: DATA_WIDTH not a multiple of BYTE_WIDTH");
  end

  (* ram_style = "block" *)
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  wr_ok;
  logic                  rd_ok;
  logic                  rd_acc;
  logic                  coll;
  logic [MW-1:0]         wa;
  logic [MW-1:0]         ra;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] cap_d;

  assign wr_ok  = wren && ({1'b0, wraddr} < DEPTH);
  assign rd_ok  = {1'b0, rdaddr} < DEPTH;
  assign rd_acc = rden && !lock;
  assign coll   = wren && rd_acc && (wraddr == rdaddr);
  assign wa     = wraddr[MW-1:0];
  assign ra     = rdaddr[MW-1:0];

  // Writes landing while reset is asserted are discarded.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      for (int i = 0; i < NBE; i++) begin
        if (wrbe[i]) begin
          mem[wa][i*BYTE_WIDTH +: BYTE_WIDTH] <=
            wrdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_old = mem[ra];
    cap_d  = '0;
    if (rd_ok) begin
      for (int i = 0; i < NBE; i++) begin
        cap_d[i*BYTE_WIDTH +: BYTE_WIDTH] =
          (WR_BYPASS != 0 && coll && wrbe[i]) ?
          wrdata[i*BYTE_WIDTH +: BYTE_WIDTH] :
          rd_old[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Entry 0 is the port capture; entries 1..RD_LATENCY are the
  // BRAM output register and the extra output registers.
  logic [RD_LATENCY:0]   vld_q;
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else if (!lock) begin
      vld_q[0] <= rd_acc;
      if (rd_acc) begin
        dat_q[0] <= cap_d;
      end
      for (int i = 1; i <= RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign rddata  = dat_q[RD_LATENCY];
  assign rdvalid = vld_q[RD_LATENCY];

endmodule

// File: tb/tb_pdp_bram_pipe.sv
// Directed bench for pdp_bram_pipe: write-first, read-first and
// latency-4 instances share one stimulus stream.
module tb_pdp_bram_pipe;

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] P1 = {16{8'h11}};
  localparam logic [127:0] P2 = {16{8'h22}};
  localparam logic [127:0] FF = {16{8'hFF}};
  localparam logic [127:0] MG = {{8{8'h11}}, {8{8'h22}}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wren;
  logic [15:0]  wrbe;
  logic [15:0]  wraddr;
  logic [127:0] wrdata;
  logic         lock;
  logic         rden;
  logic [15:0]  rdaddr;

  logic [127:0] wf_d, rf_d, l4_d;
  logic         wf_v, rf_v, l4_v;

  int nchk = 0;
  int nfail = 0;
  logic [127:0] got [$];

  always #5 clk = ~clk;

  pdp_bram_pipe #(.RD_LATENCY(2), .WR_BYPASS(1)) u_wf (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wrbe(wrbe),
    .wraddr(wraddr), .wrdata(wrdata), .lock(lock), .rden(rden),
    .rdaddr(rdaddr), .rddata(wf_d), .rdvalid(wf_v));

  pdp_bram_pipe #(.RD_LATENCY(2), .WR_BYPASS(0)) u_rf (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wrbe(wrbe),
    .wraddr(wraddr), .wrdata(wrdata), .lock(lock), .rden(rden),
    .rdaddr(rdaddr), .rddata(rf_d), .rdvalid(rf_v));

  pdp_bram_pipe #(.RD_LATENCY(4), .WR_BYPASS(1)) u_l4 (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wrbe(wrbe),
    .wraddr(wraddr), .wrdata(wrdata), .lock(lock), .rden(rden),
    .rdaddr(rdaddr), .rddata(l4_d), .rdvalid(l4_v));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer takes the output beat on any edge without lock.
  task automatic stp();
    if (wf_v && !lock) got.push_back(wf_d);
    tick();
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [127:0] d,
                    input logic [15:0] be);
    wren = 1'b1; wraddr = a; wrdata = d; wrbe = be;
    tick();
    wren = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wren = 1'b0; wrbe = '0; wraddr = '0;
    wrdata = '0; lock = 1'b0; rden = 1'b0; rdaddr = '0;
    tick(); tick();
    chk("rst_wf_d", wf_d, 128'd0);
    chk("rst_wf_v", {127'd0, wf_v}, 128'd0);
    chk("rst_rf_d", rf_d, 128'd0);
    chk("rst_rf_v", {127'd0, rf_v}, 128'd0);
    chk("rst_l4_d", l4_d, 128'd0);
    chk("rst_l4_v", {127'd0, l4_v}, 128'd0);
    rst_n = 1'b1;
    tick();

    // basic latency
    wr(16'd5, A5, 16'hFFFF);
    tick();
    rden = 1'b1; rdaddr = 16'd5;
    tick();
    rden = 1'b0;
    chk("lat_n0_v", {127'd0, wf_v}, 128'd0);
    tick();
    chk("lat_n1_v", {127'd0, wf_v}, 128'd0);
    tick();
    chk("lat_n2_v", {127'd0, wf_v}, 128'd1);
    chk("lat_n2_d", wf_d, A5);
    chk("lat_rf_d", rf_d, A5);
    tick();
    chk("lat_n3_v", {127'd0, wf_v}, 128'd0);
    chk("lat_n3_hold", wf_d, A5);
    chk("lat4_n3_v", {127'd0, l4_v}, 128'd0);
    tick();
    chk("lat4_n4_v", {127'd0, l4_v}, 128'd1);
    chk("lat4_n4_d", l4_d, A5);

    // byte enables
    wr(16'd9, 128'd0, 16'hFFFF);
    wr(16'd9, FF, 16'h0003);
    rden = 1'b1; rdaddr = 16'd9;
    tick();
    rden = 1'b0;
    tick(); tick();
    chk("be_v", {127'd0, wf_v}, 128'd1);
    chk("be_d", wf_d, 128'h0000_FFFF);

    // collision, both bypass modes
    wr(16'd3, P1, 16'hFFFF);
    wren = 1'b1; wraddr = 16'd3; wrdata = P2; wrbe = 16'h00FF;
    rden = 1'b1; rdaddr = 16'd3;
    tick();
    wren = 1'b0;
    tick();
    rden = 1'b0;
    tick();
    chk("coll_wf_d", wf_d, MG);
    chk("coll_rf_d", rf_d, P1);
    tick();
    chk("raw_rf_d", rf_d, MG);
    chk("raw_wf_d", wf_d, MG);
    chk("raw_rf_v", {127'd0, rf_v}, 128'd1);

    // lock stall
    for (int i = 0; i < 8; i++) wr(16'(i), 128'(i), 16'hFFFF);
    got.delete();
    rden = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdaddr = 16'(i);
      stp();
    end
    lock = 1'b1; rdaddr = 16'd4;
    for (int k = 0; k < 3; k++) begin
      stp();
      chk("lock_hold_d", wf_d, 128'd1);
      chk("lock_hold_v", {127'd0, wf_v}, 128'd1);
    end
    lock = 1'b0;
    for (int i = 4; i < 8; i++) begin
      rdaddr = 16'(i);
      stp();
    end
    rden = 1'b0;
    for (int k = 0; k < 4; k++) stp();
    chk("lock_count", 128'(got.size()), 128'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) chk("lock_beat", got[i], 128'(i));
    end

    // reset mid-flight
    rden = 1'b1; rdaddr = 16'd9;
    tick(); tick(); tick();
    rden = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", {127'd0, l4_v}, 128'd0);
    chk("mid_rst_d", l4_d, 128'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_v", {127'd0, l4_v}, 128'd0);
    end
    rden = 1'b1; rdaddr = 16'd9;
    tick();
    rdaddr = 16'h4000;
    tick();
    rden = 1'b0;
    tick(); tick();
    chk("oor_wf_d", wf_d, 128'd0);
    chk("oor_wf_v", {127'd0, wf_v}, 128'd1);
    tick();
    chk("pres_l4_d", l4_d, 128'h0000_FFFF);
    chk("pres_l4_v", {127'd0, l4_v}, 128'd1);
    tick();
    chk("oor_l4_d", l4_d, 128'd0);
    chk("oor_l4_v", {127'd0, l4_v}, 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pdp_bram_pipe.md
# pdp_bram_pipe

Parametrised pseudo-dual-port block RAM with byte-enable writes, a configurable read pipeline, and per-beat read-valid tracking. It replaces the single-cycle PDP buffer wherever DDR burst data is staged between the AXI master and the PL compute datapath. The block adds a same-cycle write-to-read bypass and a `lock` input that freezes the whole read pipeline without losing in-flight beats, so downstream consumers can stall.

## Interface
- `ADDR_WIDTH`, default 16: width of the read and write addresses.
- `DATA_WIDTH`, default 128: word width. Must be a multiple of `BYTE_WIDTH`.
- `MEM_DEPTH`, default 'h4000: number of words. Must be ≤ 2^ADDR_WIDTH.
- `BYTE_WIDTH`, default 8: bits per write-enable lane. NBE = DATA_WIDTH/BYTE_WIDTH.
- `RD_LATENCY`, default 2: read latency in cycles, legal range 1..4. Illegal values fail elaboration via `$error`.
- `WR_BYPASS`, default 1: 1 selects write-first behaviour on a same-address collision; 0 selects read-first.
- `clk` input, 1 bit: single clock for the block.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `wren` input, 1 bit: write request.
- `wrbe` input, NBE bits: byte-lane enables. Lane i covers `wrdata[i*BYTE_WIDTH +: BYTE_WIDTH]`.
- `wraddr` input, ADDR_WIDTH bits: write address.
- `wrdata` input, DATA_WIDTH bits: write data.
- `lock` input, 1 bit: freeze the read pipeline.
- `rden` input, 1 bit: read request.
- `rdaddr` input, ADDR_WIDTH bits: read address.
- `rddata` output, DATA_WIDTH bits: read data.
- `rdvalid` output, 1 bit: `rddata` holds the beat of an accepted read.

## Operation
- **Storage.** Memory is an array `mem[MEM_DEPTH]` with `ram_style` set to `block`. Memory contents are not reset.
- **Writes.**
  - A write commits when `wren=1`, `wraddr<MEM_DEPTH` and `wrbe` lane i is 1. Lanes with a 0 enable keep their old value.
  - `wrbe=0` is a no-op.
  - Writes are accepted regardless of `lock`.
  - Writes with `wraddr≥MEM_DEPTH` are dropped silently.
- **Read acceptance.** A read is accepted when `rden=1` and `lock=0`. `rden` is ignored while `lock=1`.
- **Read pipeline.** Stage 1 is the BRAM output register. Stages 2..RD_LATENCY are output registers. Each stage carries `{valid, data}`, and the last stage drives `rddata`/`rdvalid`.
- **Out-of-range reads.** A read with `rdaddr≥MEM_DEPTH` is still accepted and returns all-zero data with valid=1.
- **Advance.**
  - With `lock=0`, every stage shifts by one per cycle.
  - A stage's data register loads only when its incoming valid is 1. A stage's valid bit always loads.
  - As a result, `rddata` keeps the last delivered beat through bubbles, while `rdvalid` drops to 0.
- **Lock.** With `lock=1`, all stage registers hold, including valid bits. No beat is dropped or duplicated.
- **Collision.** A collision is `wren=1`, `rden=1`, `lock=0` and `wraddr==rdaddr` in the same cycle.
  - With `WR_BYPASS=1`, stage 1 captures a per-lane merge: `wrdata` on enabled lanes, old `mem` contents on the other lanes.
  - With `WR_BYPASS=0`, stage 1 captures the old contents.
- **In-flight beats.** A write in a later cycle never alters a beat already in the pipeline.
- **Reset.** Asserting `rst_n` low at any time, including mid-pipeline, clears all stage valid and data registers at once. Reads and writes in flight at that moment are discarded. Memory contents are preserved.

## Timing
- **Reset values.** `rddata=0`, `rdvalid=0`.
- **Latency.** A read accepted at clock edge N appears on `rddata` with `rdvalid=1` after edge N+RD_LATENCY, provided `lock=0` on every intervening edge. Each edge with `lock=1` adds one cycle.
- **Throughput.** One read and one write per cycle.
- **Lock on the output.** While `lock=1`, `rddata` and `rdvalid` are stable.
- **Releasing lock.** The pipeline resumes on the first edge with `lock=0`. The beat at the output is replaced on that edge.
- **Read-after-write.** A write at edge N is visible to a read accepted at edge N+1 in both modes. It is visible to a read at edge N only when `WR_BYPASS=1`.
- **Reset release.** Deasserting `rst_n` is synchronised externally. The first read can be accepted on the first edge after release.

## Test plan
1. **Basic latency.** RD_LATENCY=2. Write `mem[5]=128'hA5…A5` with all lanes enabled. Read address 5 two cycles later → `rdvalid=1` and `rddata=A5…A5` exactly 2 edges after the read edge. `rdvalid=0` one cycle before and one cycle after.
2. **Byte enables.** Preload `mem[9]=0`. Write `wrbe=16'h0003`, `wrdata=all-FF`. Read address 9 → `rddata=128'h…0000FFFF`, with only the low 16 bits set.
3. **Collision, write-first.** `WR_BYPASS=1`, `mem[3]=0x11…11`. Same cycle: write address 3 with `0x22…22`, `wrbe=16'h00FF`, and read address 3 → low 64 bits read `0x22…22`, high 64 bits read `0x11…11`.
4. **Collision, read-first.** Repeat scenario 3 with `WR_BYPASS=0` → `rddata=0x11…11`. A read one cycle later returns the merged word.
5. **Lock stall.** Stream reads of addresses 0..7, holding data values 0..7. Assert `lock` for 3 cycles mid-stream → the output holds its current beat. After release, all 8 beats arrive in order with no gaps or duplicates. The total number of `rdvalid` cycles is 8.
6. **Reset mid-flight.** RD_LATENCY=4. Issue 3 reads, then pulse `rst_n` low before any beat delivers → `rdvalid` stays 0, `rddata=0`. After reset, a read of a previously written address returns the preserved value. An out-of-range read (address 'h4000) returns 0 with `rdvalid=1`.
